alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to execute one operation; sampled on rising clk.
REQ-005 Operation  input  4  ALU operation code from the ALU controller.
REQ-006 SrcA  input  DATA_WIDTH  first operand.
REQ-007 SrcB  input  DATA_WIDTH  second operand; SrcB[4:0] is the shift amount for shifts.
REQ-008 busy  output  1  high while a multi-cycle shift is in progress.
REQ-009 done  output  1  one-cycle pulse; ALUResult/Zero valid in that cycle.
REQ-010 ALUResult  output  DATA_WIDTH  registered result, held until the next done.
REQ-011 Zero  output  1  registered, equals (ALUResult == 0), updated with ALUResult.

Function
REQ-012 Operation encoding SHALL be: 0000 AND, 0001 XOR, 0010 ADD, 0101 OR, 1010 SUB, 1100 SLT (signed), 1000 EQ, 0100 SLL, 0110 SRL, 0111 SRA.
REQ-013 EQ SHALL produce result 0 when SrcA == SrcB and 1 otherwise, so Zero=1 means equal (branch-taken for BEQ).
REQ-014 SLT SHALL produce 1 when signed SrcA < signed SrcB, else 0, zero-extended.
REQ-015 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no overflow/carry output.
REQ-016 Any undefined Operation code SHALL complete in single-cycle latency with result 0 (Zero=1).
REQ-017 FSM states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-018 start SHALL be accepted only when busy=0 (IDLE or DONE); on acceptance Operation, SrcA, SrcB[4:0] are latched.
REQ-019 start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-020 Non-shift op accepted at edge N: result registered at N, DONE state (done=1) during cycle N..N+1; latency 1 cycle.
REQ-021 Shift op with shamt=0: SHALL behave as non-shift, result = SrcA, latency 1.
REQ-022 Shift op with shamt=k>0: FSM enters SHIFT, shifts the working register by one bit per cycle for k cycles, then DONE; done asserted k+1 cycles after acceptance.
REQ-023 SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates the original MSB.
REQ-024 busy SHALL be 1 exactly in SHIFT state; done SHALL be 1 exactly in DONE state.
REQ-025 DONE SHALL return to IDLE next edge unless start=1, in which case the new operation is accepted (back-to-back issue, done may remain high on consecutive cycles).
REQ-026 ALUResult and Zero SHALL change only at the edge entering DONE; intermediate shift values SHALL not appear on ALUResult.
REQ-027 Changes on Operation/SrcA/SrcB after acceptance SHALL not affect the result.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, busy=0, done=0, ALUResult=0, Zero=1, shift counter=0, independent of clk.
REQ-029 Reset asserted mid-shift SHALL abort the operation; no done pulse SHALL follow release.
REQ-030 First start SHALL be accepted on the first rising edge after reset release.

Verification
REQ-031 ADD, SrcA=5, SrcB=7, start one cycle -> done next cycle, ALUResult=12, Zero=0, busy never high.
REQ-032 SUB 3-3 then EQ 0x1234 vs 0x1234 back-to-back -> two consecutive done cycles, both ALUResult=0, Zero=1.
REQ-033 SLL SrcA=1, SrcB=4 -> busy high 4 cycles, done on 5th cycle, ALUResult=0x10; SRA SrcA=0x80000000, SrcB=31 -> done after 32 cycles, ALUResult=0xFFFFFFFF.
REQ-034 During SRL 0xF0000000 by 8, pulse start with ADD 1+1 at cycle 3 -> ignored; result 0x00F00000, exactly one done.
REQ-035 Reset low at cycle 2 of SLL by 10 -> busy=0, done=0, ALUResult=0, Zero=1 immediately; no done after release.
REQ-036 SLT -1 vs 1 -> 1; Operation=1111 -> ALUResult=0, Zero=1, latency 1.

Source files
------------

// File: rtl/alu_exec.sv
// Execute-stage ALU with single-cycle logic/arithmetic ops and multi-cycle serial shifts.
// Handshake: start accepted when not busy; done pulses for one cycle with the registered result.
module alu_exec #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q, work_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [1:0]            kind_q, kind_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;

    logic [DATA_WIDTH-1:0] comb_res;
    logic [DATA_WIDTH-1:0] shifted;
    logic [4:0]            shamt;
    logic                  is_shift;
    logic                  accept;

    assign shamt    = SrcB[4:0];
    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
    assign accept   = start && (state_q != SHIFT);

    // Single-cycle result; shifts only land here when shamt is zero, so they pass SrcA through.
    always_comb begin
        comb_res = '0;
        case (Operation)
            OP_AND: comb_res = SrcA & SrcB;
            OP_XOR: comb_res = SrcA ^ SrcB;
            OP_ADD: comb_res = SrcA + SrcB;
            OP_OR:  comb_res = SrcA | SrcB;
            OP_SUB: comb_res = SrcA - SrcB;
            OP_SLT: comb_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_EQ:  comb_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
            OP_SLL, OP_SRL, OP_SRA: comb_res = SrcA;
            default: comb_res = '0;
        endcase
    end

    // kind_q holds Operation[1:0]: 00 SLL, 10 SRL, 11 SRA.
    always_comb begin
        shifted = '0;
        case (kind_q)
            2'b00:   shifted = work_q << 1;
            2'b10:   shifted = work_q >> 1;
            default: shifted = $unsigned($signed(work_q) >>> 1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d  = DONE;
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        state_d = SHIFT;
                        work_d  = SrcA;
                        cnt_d   = shamt;
                        kind_d  = Operation[1:0];
                    end else begin
                        state_d  = DONE;
                        result_d = comb_res;
                        zero_d   = (comb_res == '0);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            kind_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule
